// File: rtl/store_buffer.sv
// In-order store buffer that owns the datamemory port, giving loads priority over drains.
// Optional SB_FORWARD_EN: word loads exactly matching the youngest pending SW are served from the buffer.
module store_buffer #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int SB_DEPTH   = 4,
  parameter bit SLOT_CHECK = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          st_valid,
  output logic                          st_ready,
  input  logic [DM_ADDRESS-1:0]         st_addr,
  input  logic [DATA_W-1:0]             st_data,
  input  logic [2:0]                    st_funct3,
  input  logic                          ld_req,
  input  logic [DM_ADDRESS-1:0]         ld_addr,
  input  logic [2:0]                    ld_funct3,
  output logic                          ld_stall,
  output logic                          ld_fwd_valid,
  output logic [DATA_W-1:0]             ld_fwd_data,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [DM_ADDRESS-1:0]         mem_a,
  output logic [DATA_W-1:0]             mem_wd,
  output logic [2:0]                    mem_funct3,
  output logic                          sb_empty,
  output logic [$clog2(SB_DEPTH):0]     sb_count
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DM_ADDRESS-1:0] addr_mem [SB_DEPTH];
  logic [DATA_W-1:0]     data_mem [SB_DEPTH];
  logic [2:0]            f3_mem   [SB_DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [SB_DEPTH-1:0] match;
  logic hit, fwd, load_port, pop, push;

  // An entry is live when its distance from head is below the count.
  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] age;
      assign age       = PTR_W'(gi) - head_q;
      assign match[gi] = ({1'b0, age} < count_q) &&
                         (addr_mem[gi][DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2]);
    end
  endgenerate

  assign hit = ld_req && (|match);

`ifdef SB_FORWARD_EN
  logic [PTR_W-1:0] young_idx;
  always_comb begin
    young_idx = head_q;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (match[head_q + PTR_W'(k)]) young_idx = head_q + PTR_W'(k);
    end
  end
  assign fwd = hit && (ld_funct3 == 3'b010) && (f3_mem[young_idx] == 3'b010) &&
               (addr_mem[young_idx] == ld_addr);
  assign ld_fwd_data = fwd ? data_mem[young_idx] : '0;
`else
  assign fwd         = 1'b0;
  assign ld_fwd_data = '0;
`endif

  assign ld_fwd_valid = fwd;
  assign ld_stall     = hit && !fwd;
  assign load_port    = ld_req && !hit;
  assign pop          = (count_q != '0) && !load_port;
  assign st_ready     = (count_q < CNT_W'(SB_DEPTH)) || pop;
  assign push         = st_valid && st_ready;
  assign sb_empty     = (count_q == '0);
  assign sb_count     = count_q;

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    mem_funct3 = '0;
    if (load_port) begin
      mem_read   = 1'b1;
      mem_a      = ld_addr;
      mem_funct3 = ld_funct3;
    end else if (pop) begin
      mem_write  = 1'b1;
      mem_a      = addr_mem[head_q];
      mem_wd     = data_mem[head_q];
      mem_funct3 = f3_mem[head_q];
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: liveness comes solely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= st_addr;
      data_mem[tail_q] <= st_data;
      f3_mem[tail_q]   <= st_funct3;
    end
  end

  generate
    if (SLOT_CHECK) begin : g_slot_check
      a_single_mem_slot: assert property (@(posedge clk) disable iff (!rst_n)
                                          !(st_valid && ld_req));
    end
  endgenerate
endmodule
